// File: rtl/pd_pkg.sv
// Shared predecode types: jump_t classification codes, control-flow opcodes
// and the J/B immediate sign-extension helpers.
package pd_pkg;

  typedef enum logic [2:0] {
    NO_CFLOW = 3'd0,
    COND_BR  = 3'd1,
    RET      = 3'd2,
    J        = 3'd3,
    JR       = 3'd4,
    JAL      = 3'd5,
    JALR     = 3'd6
  } jump_t;

  localparam logic [6:0] OP_BRANCH = 7'h63;
  localparam logic [6:0] OP_JALR   = 7'h67;
  localparam logic [6:0] OP_JAL    = 7'h6f;

  function automatic logic signed [31:0] sext_jimm(input logic [31:0] insn);
    logic [20:0] imm;
    imm = {insn[31], insn[19:12], insn[20], insn[30:21], 1'b0};
    return 32'($signed(imm));
  endfunction

  function automatic logic signed [31:0] sext_bimm(input logic [31:0] insn);
    logic [12:0] imm;
    imm = {insn[31], insn[7], insn[30:25], insn[11:8], 1'b0};
    return 32'($signed(imm));
  endfunction

  function automatic logic is_link(input logic [4:0] r);
    return (r == 5'd1) || (r == 5'd5);
  endfunction

endpackage

// File: rtl/predecode_lane.sv
// Combinational predecode of one fetch slot: jump_t code, static target
// (J-type or B-type relative to slot_pc) and the backward-branch flag.
module predecode_lane
  import pd_pkg::*;
#(
  parameter int unsigned XLEN = 64
) (
  input  logic [31:0]     insn,
  input  logic [XLEN-1:0] slot_pc,
  output logic [2:0]      pd,
  output logic [XLEN-1:0] target,
  output logic            backward
);

  logic [6:0] opcode;
  logic [4:0] rd;
  logic [4:0] rs1;
  jump_t      cls;

  assign opcode = insn[6:0];
  assign rd     = insn[11:7];
  assign rs1    = insn[19:15];

  always_comb begin
    cls      = NO_CFLOW;
    target   = '0;
    backward = 1'b0;
    case (opcode)
      OP_BRANCH: begin
        cls      = COND_BR;
        target   = slot_pc + XLEN'(sext_bimm(insn));
        backward = insn[31];
      end
      OP_JALR: begin
        if (rd != 5'd0)    cls = JALR;
        else if (is_link(rs1)) cls = RET;
        else               cls = JR;
      end
      OP_JAL: begin
        cls    = is_link(rd) ? JAL : J;
        target = slot_pc + XLEN'(sext_jimm(insn));
      end
      default: cls = NO_CFLOW;
    endcase
  end

  assign pd = cls;

endmodule

// File: rtl/predecode_bundle.sv
// Registered N-lane bundle predecode with first-cflow redirect prediction and
// dead-slot trimming. Define PD_RAS_EN to add the return-address stack.
module predecode_bundle
  import pd_pkg::*;
#(
  parameter int unsigned LANES     = 4,
  parameter int unsigned XLEN      = 64,
  parameter int unsigned RAS_DEPTH = 8
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic                    flush,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [XLEN-1:0]         in_pc,
  input  logic [32*LANES-1:0]     in_insns,
  input  logic [LANES-1:0]        in_mask,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [XLEN-1:0]         out_pc,
  output logic [32*LANES-1:0]     out_insns,
  output logic [LANES-1:0]        out_mask,
  output logic [3*LANES-1:0]      out_pd,
  output logic                    out_has_cflow,
  output logic [((LANES > 1) ? $clog2(LANES) : 1)-1:0] out_cflow_slot,
  output logic                    out_redirect,
  output logic [XLEN-1:0]         out_target
);

  localparam int unsigned SW = (LANES > 1) ? $clog2(LANES) : 1;

  if (LANES < 1 || LANES > 8 || (LANES & (LANES - 1)) != 0 ||
      RAS_DEPTH < 1 || (RAS_DEPTH & (RAS_DEPTH - 1)) != 0) begin : g_bad_cfg
    $error("predecode_bundle: LANES and RAS_DEPTH must be powers of 2");
  end

  logic [2:0]      lane_pd   [LANES];
  logic [XLEN-1:0] lane_pc   [LANES];
  logic [XLEN-1:0] lane_tgt  [LANES];
  logic            lane_back [LANES];

  logic             xfer;
  logic             found;
  logic [SW-1:0]    sel;
  jump_t            sel_pd;
  logic [XLEN-1:0]  sel_tgt;
  logic             sel_back;
  logic             redirect_n;
  logic [XLEN-1:0]  target_n;
  logic [LANES-1:0] mask_n;
  logic [3*LANES-1:0] pd_n;

`ifdef PD_RAS_EN
  localparam int unsigned PW = (RAS_DEPTH > 1) ? $clog2(RAS_DEPTH) : 1;
  localparam logic [PW:0] RAS_FULL = (PW + 1)'(RAS_DEPTH);

  logic [XLEN-1:0] ras_mem [RAS_DEPTH];
  logic [PW-1:0]   ras_ptr;
  logic [PW-1:0]   ras_ptr_inc;
  logic [PW-1:0]   ras_ptr_dec;
  logic [PW:0]     ras_count;
  logic [XLEN-1:0] ras_top;
  logic            ras_push;
  logic            ras_pop;

  assign ras_ptr_inc = (ras_ptr == PW'(RAS_DEPTH - 1)) ? '0 : ras_ptr + PW'(1);
  assign ras_ptr_dec = (ras_ptr == '0) ? PW'(RAS_DEPTH - 1) : ras_ptr - PW'(1);
  assign ras_top     = ras_mem[ras_ptr_dec];
`endif

  for (genvar i = 0; i < LANES; i++) begin : g_lane
    assign lane_pc[i] = in_pc + XLEN'(4 * i);
    predecode_lane #(.XLEN(XLEN)) u_lane (
      .insn     (in_insns[32*i +: 32]),
      .slot_pc  (lane_pc[i]),
      .pd       (lane_pd[i]),
      .target   (lane_tgt[i]),
      .backward (lane_back[i])
    );
  end

  assign in_ready = !out_valid | out_ready;
  assign xfer     = in_valid & in_ready & !flush;

  // Only the lowest valid cflow slot decides; a non-redirecting first slot
  // ends the decision even if a later slot would have redirected.
  always_comb begin
    found    = 1'b0;
    sel      = '0;
    sel_pd   = NO_CFLOW;
    sel_tgt  = '0;
    sel_back = 1'b0;
    for (int unsigned i = 0; i < LANES; i++) begin
      if (!found && in_mask[i] && lane_pd[i] != 3'd0) begin
        found    = 1'b1;
        sel      = SW'(i);
        sel_pd   = jump_t'(lane_pd[i]);
        sel_tgt  = lane_tgt[i];
        sel_back = lane_back[i];
      end
    end

    redirect_n = 1'b0;
    target_n   = '0;
    case (sel_pd)
      J, JAL: begin
        redirect_n = 1'b1;
        target_n   = sel_tgt;
      end
      COND_BR: begin
        redirect_n = sel_back;
        target_n   = sel_back ? sel_tgt : '0;
      end
      RET: begin
`ifdef PD_RAS_EN
        if (ras_count != '0) begin
          redirect_n = 1'b1;
          target_n   = ras_top;
        end
`endif
      end
      default: redirect_n = 1'b0;
    endcase

    mask_n = in_mask;
    pd_n   = '0;
    for (int unsigned i = 0; i < LANES; i++) begin
      if (redirect_n && SW'(i) > sel) mask_n[i] = 1'b0;
      if (mask_n[i]) pd_n[3*i +: 3] = lane_pd[i];
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      out_valid      <= 1'b0;
      out_pc         <= '0;
      out_insns      <= '0;
      out_mask       <= '0;
      out_pd         <= '0;
      out_has_cflow  <= 1'b0;
      out_cflow_slot <= '0;
      out_redirect   <= 1'b0;
      out_target     <= '0;
    end else if (flush) begin
      out_valid <= 1'b0;
    end else if (xfer) begin
      out_valid      <= 1'b1;
      out_pc         <= in_pc;
      out_insns      <= in_insns;
      out_mask       <= mask_n;
      out_pd         <= pd_n;
      out_has_cflow  <= found;
      out_cflow_slot <= sel;
      out_redirect   <= redirect_n;
      out_target     <= target_n;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

`ifdef PD_RAS_EN
  assign ras_push = xfer && (sel_pd == JAL || sel_pd == JALR);
  assign ras_pop  = xfer && (sel_pd == RET) && (ras_count != '0);

  // Circular stack: pushing when full silently overwrites the oldest entry.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ras_ptr   <= '0;
      ras_count <= '0;
    end else if (ras_push) begin
      ras_ptr <= ras_ptr_inc;
      if (ras_count != RAS_FULL) ras_count <= ras_count + 1'b1;
    end else if (ras_pop) begin
      ras_ptr   <= ras_ptr_dec;
      ras_count <= ras_count - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (ras_push) ras_mem[ras_ptr] <= in_pc + XLEN'({sel, 2'b00}) + XLEN'(4);
  end
`endif

endmodule

// File: tb/tb_predecode_bundle.sv
// Directed plus randomized bench for predecode_bundle; the reference model
// works from the generated instruction fields (kind, rd, rs1, immediate).
module tb_predecode_bundle;

  localparam int LANES = 4;
  localparam int XLEN = 64;
  localparam int RAS_DEPTH = 8;
  localparam int K_ADDI = 0, K_LW = 1, K_BR = 2, K_JAL = 3, K_JALR = 4;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  logic flush = 1'b0;
  logic in_valid = 1'b0;
  logic out_ready = 1'b1;
  logic in_ready, out_valid, out_has_cflow, out_redirect;
  logic [63:0] in_pc = '0;
  logic [63:0] out_pc, out_target;
  logic [127:0] in_insns = '0;
  logic [127:0] out_insns;
  logic [3:0] in_mask = '0;
  logic [3:0] out_mask;
  logic [11:0] out_pd;
  logic [1:0] out_cflow_slot;

  always #5 clk = ~clk;

  predecode_bundle #(.LANES(LANES), .XLEN(XLEN), .RAS_DEPTH(RAS_DEPTH)) dut (
    .clk(clk), .reset_n(reset_n), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_pc(in_pc),
    .in_insns(in_insns), .in_mask(in_mask),
    .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc),
    .out_insns(out_insns), .out_mask(out_mask), .out_pd(out_pd),
    .out_has_cflow(out_has_cflow), .out_cflow_slot(out_cflow_slot),
    .out_redirect(out_redirect), .out_target(out_target)
  );

  int nvec = 0;
  int nerr = 0;

  logic [31:0] s_insn [4];
  int          s_cls  [4];
  longint      s_imm  [4];
  logic [63:0] ras_q [$];

  logic        e_valid, e_has, e_red;
  logic [63:0] e_pc, e_tgt;
  logic [127:0] e_insns;
  logic [3:0]  e_mask;
  logic [11:0] e_pd;
  logic [1:0]  e_slot;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    nvec++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_out(input string tag);
    chk({tag, ".valid"},    128'(out_valid),      128'(e_valid));
    chk({tag, ".pc"},       128'(out_pc),         128'(e_pc));
    chk({tag, ".insns"},    out_insns,            e_insns);
    chk({tag, ".mask"},     128'(out_mask),       128'(e_mask));
    chk({tag, ".pd"},       128'(out_pd),         128'(e_pd));
    chk({tag, ".has"},      128'(out_has_cflow),  128'(e_has));
    chk({tag, ".slot"},     128'(out_cflow_slot), 128'(e_slot));
    chk({tag, ".redirect"}, 128'(out_redirect),   128'(e_red));
    chk({tag, ".target"},   128'(out_target),     128'(e_tgt));
  endtask

  function automatic logic [31:0] enc_i(input logic [6:0] op, input logic [4:0] rd,
                                        input logic [4:0] rs1, input logic [11:0] imm);
    return {imm, rs1, 3'b000, rd, op};
  endfunction

  function automatic logic [31:0] enc_j(input logic [4:0] rd, input logic [20:0] imm);
    return {imm[20], imm[10:1], imm[11], imm[19:12], rd, 7'h6f};
  endfunction

  function automatic logic [31:0] enc_b(input logic [12:0] imm, input logic [4:0] rs1);
    return {imm[12], imm[10:5], 5'd2, rs1, 3'b000, imm[4:1], imm[11], 7'h63};
  endfunction

  function automatic bit is_link(input int r);
    return r == 1 || r == 5;
  endfunction

  task automatic set_slot(input int i, input int kind, input int rd, input int rs1, input longint imm);
    s_imm[i] = imm;
    case (kind)
      K_ADDI: begin s_insn[i] = enc_i(7'h13, 5'(rd), 5'(rs1), 12'(imm)); s_cls[i] = 0; end
      K_LW:   begin s_insn[i] = enc_i(7'h03, 5'(rd), 5'(rs1), 12'(imm)); s_cls[i] = 0; end
      K_BR:   begin s_insn[i] = enc_b(13'(imm), 5'(rs1)); s_cls[i] = 1; end
      K_JAL:  begin s_insn[i] = enc_j(5'(rd), 21'(imm)); s_cls[i] = is_link(rd) ? 5 : 3; end
      default: begin
        s_insn[i] = enc_i(7'h67, 5'(rd), 5'(rs1), 12'(imm));
        s_cls[i] = (rd != 0) ? 6 : (is_link(rs1) ? 2 : 4);
      end
    endcase
  endtask

  task automatic fill_addi();
    for (int i = 0; i < 4; i++) set_slot(i, K_ADDI, 1, 0, 1);
  endtask

  // Expected outputs for an accepted bundle, from the architectural rules.
  task automatic model(input logic [63:0] pc, input logic [3:0] mask);
    bit found;
    logic [63:0] spc;
    found = 0;
    e_pc = pc; e_mask = mask; e_has = 0; e_slot = 0; e_red = 0; e_tgt = 0; e_pd = 0;
    for (int i = 0; i < 4; i++) e_insns[32*i +: 32] = s_insn[i];
    for (int i = 0; i < 4; i++) begin
      if (!found && mask[i] && s_cls[i] != 0) begin
        found = 1; e_has = 1; e_slot = 2'(i);
        spc = pc + 64'(4 * i);
        case (s_cls[i])
          3, 5: begin e_red = 1; e_tgt = spc + 64'(s_imm[i]); end
          1: if (s_imm[i] < 0) begin e_red = 1; e_tgt = spc + 64'(s_imm[i]); end
          2: begin
`ifdef PD_RAS_EN
            if (ras_q.size() > 0) begin e_red = 1; e_tgt = ras_q.pop_back(); end
`endif
          end
          default: e_red = 0;
        endcase
`ifdef PD_RAS_EN
        if (s_cls[i] == 5 || s_cls[i] == 6) begin
          ras_q.push_back(spc + 64'd4);
          if (ras_q.size() > RAS_DEPTH) void'(ras_q.pop_front());
        end
`endif
      end
    end
    if (e_red) for (int i = 0; i < 4; i++) if (i > int'(e_slot)) e_mask[i] = 1'b0;
    for (int i = 0; i < 4; i++) if (e_mask[i]) e_pd[3*i +: 3] = 3'(s_cls[i]);
  endtask

  task automatic drive(input logic [63:0] pc, input logic [3:0] mask);
    in_pc = pc; in_mask = mask;
    for (int i = 0; i < 4; i++) in_insns[32*i +: 32] = s_insn[i];
    in_valid = 1'b1;
  endtask

  // Called at a falling edge; returns at the falling edge after the transfer.
  task automatic xfer(input logic [63:0] pc, input logic [3:0] mask, input string tag);
    int k;
    drive(pc, mask);
    k = 0;
    while (!in_ready && k < 50) begin @(negedge clk); k++; end
    chk({tag, ".ready"}, 128'(in_ready), 128'(1));
    @(posedge clk);
    model(pc, mask);
    e_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    check_out(tag);
  endtask

  initial begin
    logic [20:0] rj;
    logic [12:0] rb;
    logic [63:0] pc;
    int kind, rd, rs1;
    int regs [4];
    regs = '{0, 1, 5, 7};

    // reset state
    e_valid = 0; e_has = 0; e_red = 0; e_pc = 0; e_tgt = 0;
    e_insns = 0; e_mask = 0; e_pd = 0; e_slot = 0;
    repeat (2) @(negedge clk);
    check_out("reset");
    reset_n = 1'b1;
    @(negedge clk);

    // dataflow: jal x0,+0x40 in slot 2
    fill_addi();
    set_slot(2, K_JAL, 0, 0, 64'h40);
    xfer(64'h1000, 4'b1111, "jal_slot2");

    // backpressure holds outputs
    fill_addi();
    out_ready = 1'b0;
    drive(64'h1100, 4'b1111);
    repeat (3) begin
      @(negedge clk);
      chk("bp.in_ready", 128'(in_ready), 128'(0));
      check_out("bp.hold");
    end
    out_ready = 1'b1;
    xfer(64'h1100, 4'b1111, "bp.accept");

    // forward branch first, backward branch behind it
    fill_addi();
    set_slot(0, K_BR, 0, 3, 64'h20);
    set_slot(1, K_BR, 0, 3, -64'sd8);
    xfer(64'h1000, 4'b1111, "br.fwd_first");
    xfer(64'h1000, 4'b1110, "br.back");

    // classification (RAS still empty here)
    set_slot(0, K_JALR, 0, 1, 0);
    set_slot(1, K_JALR, 0, 7, 0);
    set_slot(2, K_JALR, 1, 7, 0);
    set_slot(3, K_ADDI, 1, 0, 1);
    xfer(64'h1200, 4'b1111, "cls.jalr");
    fill_addi();
    set_slot(0, K_LW, 3, 2, 8);
    set_slot(1, K_JAL, 5, 0, 64'h100);
    xfer(64'h1300, 4'b1111, "cls.jal_x5");
    fill_addi();
    set_slot(3, K_JAL, 3, 0, -64'sd16);
    xfer(64'h1400, 4'b1111, "cls.jal_x3");

    // call/return pair
    fill_addi();
    set_slot(0, K_JAL, 1, 0, 64'h100);
    xfer(64'h2000, 4'b0001, "ras.call");
    set_slot(0, K_JALR, 0, 1, 0);
    xfer(64'h3000, 4'b0001, "ras.ret");

    // overflow: nine calls then nine returns
    for (int k = 0; k < 9; k++) begin
      set_slot(0, K_JAL, 1, 0, 64'h40);
      xfer(64'h4000 + 64'(k * 256), 4'b0001, "ras.push");
    end
    for (int k = 0; k < 9; k++) begin
      set_slot(0, K_JALR, 0, 5, 0);
      xfer(64'h5000 + 64'(k * 16), 4'b0001, "ras.pop");
    end

    // flush drops held bundle and same-cycle input; RAS untouched
    fill_addi();
    set_slot(0, K_JAL, 1, 0, 64'h80);
    xfer(64'h6000, 4'b0001, "pre_flush");
    set_slot(0, K_JAL, 5, 0, 64'h200);
    drive(64'h7000, 4'b0001);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    in_valid = 1'b0;
    chk("flush.valid", 128'(out_valid), 128'(0));
    @(negedge clk);
    chk("flush.dropped", 128'(out_valid), 128'(0));
    set_slot(0, K_JALR, 0, 1, 0);
    xfer(64'h8000, 4'b0001, "flush.ret");

    // randomized bundles
    for (int n = 0; n < 300; n++) begin
      for (int i = 0; i < 4; i++) begin
        kind = $urandom_range(0, 4);
        rd   = regs[$urandom_range(0, 3)];
        rs1  = regs[$urandom_range(0, 3)];
        rj = 21'($urandom); rj[0] = 1'b0;
        rb = 13'($urandom); rb[0] = 1'b0;
        case (kind)
          K_JAL:   set_slot(i, kind, rd, rs1, longint'($signed(rj)));
          K_BR:    set_slot(i, kind, rd, rs1, longint'($signed(rb)));
          default: set_slot(i, kind, rd, rs1, longint'($urandom_range(0, 2047)));
        endcase
      end
      pc = {32'($urandom), 32'($urandom)} & ~64'h3;
      if (n % 10 == 0) pc = 64'hFFFF_FFFF_FFFF_FFF0;
      xfer(pc, 4'($urandom), "rand");
    end

    // asynchronous reset while a bundle is held
    fill_addi();
    set_slot(0, K_JAL, 1, 0, 64'h40);
    xfer(64'h9000, 4'b1111, "pre_reset");
    out_ready = 1'b0;
    #2 reset_n = 1'b0;
    #1;
    e_valid = 0; e_has = 0; e_red = 0; e_pc = 0; e_tgt = 0;
    e_insns = 0; e_mask = 0; e_pd = 0; e_slot = 0;
    check_out("rst_async");
    ras_q.delete();
    @(negedge clk);
    reset_n = 1'b1;
    out_ready = 1'b1;
    @(negedge clk);
    set_slot(0, K_JALR, 0, 1, 0);
    xfer(64'hA000, 4'b0001, "rst.ret_empty");

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
